// File: rtl/keyevt_pkg.sv
// keyevt_pkg: shared constants and types for keycode_event_pio.
//   - Avalon register addresses (DATA / STATUS / CONTROL).
//   - Bit positions inside the DATA, STATUS and CONTROL words.
//   - keyevt_entry_t: one queued event (keycode, plus a capture timestamp
//     when the KEYEVT_TIMESTAMP_EN macro is defined).
package keyevt_pkg;

  localparam int unsigned KEYEVT_DATA_W = 16;
  localparam int unsigned KEYEVT_TS_W   = 14;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int unsigned DATA_VALID_BIT      = 31;
  localparam int unsigned DATA_TS_LSB         = 16;
  localparam int unsigned STATUS_EMPTY_BIT    = 8;
  localparam int unsigned STATUS_FULL_BIT     = 9;
  localparam int unsigned STATUS_OVF_BIT      = 10;
  localparam int unsigned CTRL_IRQ_EN_BIT     = 0;
  localparam int unsigned CTRL_CAPTURE_EN_BIT = 1;

  typedef struct packed {
`ifdef KEYEVT_TIMESTAMP_EN
    logic [KEYEVT_TS_W-1:0]   ts;
`endif
    logic [KEYEVT_DATA_W-1:0] data;
  } keyevt_entry_t;

  localparam int unsigned KEYEVT_ENTRY_W = $bits(keyevt_entry_t);

endpackage

// File: rtl/keyevt_fifo.sv
// keyevt_fifo: synchronous FIFO for queued key events.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_push, i_data      write request and entry
//   i_pop               read request (ignored while empty)
//   o_head              oldest entry (stale content while empty)
//   o_count             occupancy 0..DEPTH
//   o_full, o_empty     occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module keyevt_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign w_pop_ok  = i_pop & ~o_empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array; written at the tail on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_pio.sv
// keycode_event_pio: Avalon-MM input PIO that queues every change of a
// keycode bus and lets the CPU pop the events.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   address, chipselect, read_n,   Avalon-MM slave (read latency 0,
//   write_n, writedata, readdata   no waitrequest)
//   in_port                        keycode bus, synchronous to clk
//   irq                            level interrupt: irq_en & events pending
// Register map: 0 DATA (read pops), 1 STATUS, 2 CONTROL, 3 reserved.
// Build option: define KEYEVT_TIMESTAMP_EN to store a free-running cycle
// stamp with each event and return it in DATA[16 +: TS_WIDTH].
import keyevt_pkg::*;

module keycode_event_pio #(
  parameter int unsigned DATA_WIDTH = KEYEVT_DATA_W,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_WIDTH   = KEYEVT_TS_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] r_in_q;
  logic                  r_irq_en;
  logic                  r_capture_en;
  logic                  r_overflow;
`ifdef KEYEVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]   r_ts;
`endif

  logic                  w_rd_stb;
  logic                  w_wr_stb;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  keyevt_entry_t         w_push_entry;
  keyevt_entry_t         w_head;
  logic [CNT_W-1:0]      w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_unused;

  assign w_rd_stb  = chipselect & ~read_n;
  assign w_wr_stb  = chipselect & ~write_n;
  assign w_pop     = w_rd_stb & (address == ADDR_DATA);
  assign w_push    = (in_port != r_in_q) & r_capture_en;
  // A pop alongside a full-queue push makes room, so only a lone push overflows.
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_ovf_clr = w_wr_stb & (address == ADDR_STATUS) & writedata[STATUS_OVF_BIT];
  assign irq       = r_irq_en & ~w_empty;
  assign w_unused  = ^{writedata[31:11], writedata[9:2], TS_WIDTH[0]};

  // Assemble the entry that a change event pushes.
  always_comb begin
    w_push_entry.data = in_port;
`ifdef KEYEVT_TIMESTAMP_EN
    w_push_entry.ts   = r_ts;
`endif
  end

  keyevt_fifo #(
    .WIDTH (KEYEVT_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Input sampler: tracks in_port even while capture is off, so re-enabling
  // capture never queues a stale change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_q <= {DATA_WIDTH{1'b0}};
    end else begin
      r_in_q <= in_port;
    end
  end

  // CONTROL register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en     <= 1'b0;
      r_capture_en <= 1'b1;
    end else if (w_wr_stb && (address == ADDR_CTRL)) begin
      r_irq_en     <= writedata[CTRL_IRQ_EN_BIT];
      r_capture_en <= writedata[CTRL_CAPTURE_EN_BIT];
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef KEYEVT_TIMESTAMP_EN
  // Free-running cycle stamp, wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts <= {TS_WIDTH{1'b0}};
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end
`endif

  // Zero-latency read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA: begin
        if (!w_empty) begin
          readdata[DATA_VALID_BIT]        = 1'b1;
          readdata[KEYEVT_DATA_W-1:0]     = w_head.data;
`ifdef KEYEVT_TIMESTAMP_EN
          readdata[DATA_TS_LSB +: KEYEVT_TS_W] = w_head.ts;
`endif
        end else begin
          readdata = 32'd0;
        end
      end
      ADDR_STATUS: begin
        readdata[CNT_W-1:0]        = w_count;
        readdata[STATUS_EMPTY_BIT] = w_empty;
        readdata[STATUS_FULL_BIT]  = w_full;
        readdata[STATUS_OVF_BIT]   = r_overflow;
      end
      ADDR_CTRL: begin
        readdata[CTRL_IRQ_EN_BIT]     = r_irq_en;
        readdata[CTRL_CAPTURE_EN_BIT] = r_capture_en;
      end
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_keycode_event_pio.sv
// Testbench for keycode_event_pio: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_keycode_event_pio;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] in_port = 16'd0;
  logic        irq;

  always #5 clk = ~clk;

  keycode_event_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_q[$];
  logic        m_ovf;
  logic        m_irq_en;
  logic        m_cap;
  logic [15:0] m_inq;
  int unsigned m_ts;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_irq_en = 1'b0;
    m_cap = 1'b1;
    m_inq = 16'd0;
    m_ts = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    int sz;
    sz = m_q.size();
    case (a)
      2'd0:    return (sz != 0) ? (32'h8000_0000 | m_q[0]) : 32'd0;
      2'd1:    return {21'd0, m_ovf, (sz == DEPTH), (sz == 0), 4'd0, 4'(sz)};
      2'd2:    return {30'd0, m_cap, m_irq_en};
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: called just after a negedge, drives inputs, checks the
  // DUT against the model, advances the model by one edge, ends at the next negedge.
  task automatic cyc(input logic c, input logic rn, input logic wn, input logic [1:0] a,
                     input logic [31:0] wd, input logic [15:0] ip, output logic [31:0] rd);
    bit pop, push, full, set_ovf;
    logic [31:0] ent;
    chipselect = c; read_n = rn; write_n = wn; address = a; writedata = wd; in_port = ip;
    #1;
    rd = readdata;
    check_eq("readdata", readdata, exp_rd(a));
    check_eq("irq", {31'd0, irq}, {31'd0, (m_irq_en && m_q.size() != 0)});
    pop = c && !rn && (a == 2'd0) && (m_q.size() != 0);
    push = (ip != m_inq) && m_cap;
    full = (m_q.size() == DEPTH);
    set_ovf = 1'b0;
`ifdef KEYEVT_TIMESTAMP_EN
    ent = {2'd0, 14'(m_ts % 16384), ip};
`else
    ent = {16'd0, ip};
`endif
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (full && !pop) set_ovf = 1'b1;
      else m_q.push_back(ent);
    end
    if (c && !wn) begin
      if (a == 2'd1 && wd[10]) m_ovf = 1'b0;
      if (a == 2'd2) begin
        m_irq_en = wd[0];
        m_cap = wd[1];
      end
    end
    if (set_ovf) m_ovf = 1'b1;
    m_inq = ip;
    m_ts++;
    @(negedge clk);
  endtask

  task automatic idle(input logic [15:0] ip);
    logic [31:0] rd;
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 32'd0, ip, rd);
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [15:0] ip, output logic [31:0] rd);
    cyc(1'b1, 1'b0, 1'b1, a, 32'd0, ip, rd);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd, input logic [15:0] ip);
    logic [31:0] rd;
    cyc(1'b1, 1'b1, 1'b0, a, wd, ip, rd);
  endtask

  // Asserted at a negedge, released at the following one.
  task automatic do_reset();
    reset = 1'b1;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = 2'd0;
    model_reset();
    #1;
    check_eq("reset_rdata", readdata, 32'd0);
    check_eq("reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] rd, rd2;
  logic [15:0] ip;

  initial begin
    @(negedge clk);
    do_reset();

    // 1: first change is captured, popped once, then queue empty
    idle(16'h0000);
    idle(16'h001C);
    rd_reg(2'd0, 16'h001C, rd);
    check_eq("t1_data", rd & 32'h8000_FFFF, 32'h8000_001C);
    rd_reg(2'd0, 16'h001C, rd);
    check_eq("t1_empty_read", rd, 32'd0);
    rd_reg(2'd1, 16'h001C, rd);
    check_eq("t1_count", rd & 32'h0000_010F, 32'h0000_0100);

    // 2: irq follows pending events
    wr_reg(2'd2, 32'd3, 16'h001C);
    idle(16'h0055);
    check_eq("t2_irq_rise", {31'd0, irq}, 32'd1);
    rd_reg(2'd0, 16'h0055, rd);
    check_eq("t2_irq_fall", {31'd0, irq}, 32'd0);

    // 3: overflow on ninth change, order preserved, clear overflow
    for (int i = 0; i < 9; i++) idle(16'h0100 + 16'(i));
    rd_reg(2'd1, 16'h0108, rd);
    check_eq("t3_status", rd & 32'h0000_070F, 32'h0000_0608);
    for (int i = 0; i < 8; i++) begin
      rd_reg(2'd0, 16'h0108, rd);
      check_eq("t3_pop", {16'd0, rd[15:0]}, 32'h0100 + 32'(i));
    end
    wr_reg(2'd1, 32'h0000_0400, 16'h0108);
    rd_reg(2'd1, 16'h0108, rd);
    check_eq("t3_ovf_clr", rd & 32'h0000_0400, 32'd0);

    // 4: full queue, pop and change in the same cycle
    for (int i = 0; i < 8; i++) idle(16'h0200 + 16'(i));
    rd_reg(2'd0, 16'h02AA, rd);
    check_eq("t4_head", {16'd0, rd[15:0]}, 32'h0200);
    rd_reg(2'd1, 16'h02AA, rd);
    check_eq("t4_status", rd & 32'h0000_070F, 32'h0000_0208);
    for (int i = 1; i < 9; i++) begin
      rd_reg(2'd0, 16'h02AA, rd);
      check_eq("t4_drain", {16'd0, rd[15:0]}, (i == 8) ? 32'h02AA : 32'h0200 + 32'(i));
    end

    // 5: capture disabled, then reset mid-burst
    wr_reg(2'd2, 32'd1, 16'h02AA);
    idle(16'h0011);
    idle(16'h0022);
    idle(16'h0033);
    wr_reg(2'd2, 32'd3, 16'h0033);
    idle(16'h0033);
    rd_reg(2'd1, 16'h0033, rd);
    check_eq("t5_no_stale", rd, 32'h0000_0100);
    idle(16'h0044);
    idle(16'h0045);
    do_reset();
    rd_reg(2'd1, 16'h0000, rd);
    check_eq("t5_rst_status", rd, 32'h0000_0100);
    rd_reg(2'd2, 16'h0000, rd);
    check_eq("t5_rst_ctrl", rd, 32'h0000_0002);

    // 6: timestamp spacing / zero upper DATA field
    idle(16'h0A01);
    for (int i = 0; i < 4; i++) idle(16'h0A01);
    idle(16'h0A02);
    rd_reg(2'd0, 16'h0A02, rd);
    rd_reg(2'd0, 16'h0A02, rd2);
`ifdef KEYEVT_TIMESTAMP_EN
    check_eq("t6_ts_diff", {18'd0, 14'(rd2[29:16] - rd[29:16])}, 32'd5);
`else
    check_eq("t6_upper_zero", {17'd0, rd[30:16]}, 32'd0);
`endif
    check_eq("t6_second", {16'd0, rd2[15:0]}, 32'h0A02);

    // randomized traffic
    ip = 16'h0A02;
    for (int n = 0; n < 3000; n++) begin
      int op;
      if ($urandom_range(0, 2) == 0) ip = 16'($urandom_range(0, 15));
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if (op < 3) begin
        rd_reg(2'd0, ip, rd);
      end else if (op < 5) begin
        rd_reg(2'($urandom_range(0, 3)), ip, rd);
      end else if (op == 5) begin
        wr_reg(2'd1, $urandom, ip);
      end else if (op == 6) begin
        wr_reg(2'd2, {30'd0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1))}, ip);
      end else begin
        idle(ip);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
